// File: rtl/axi_stall_pkg.sv
// Shared stall-buffer definitions: LFSR feedback polynomial, per-beat countdown type and delay cap.
package axi_stall_pkg;

  // Galois right-shift feedback for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int unsigned MAX_DELAY = 15;

  typedef logic [3:0] cnt_t;

  function automatic cnt_t clamp_cnt(input int unsigned v);
    return (v > MAX_DELAY) ? cnt_t'(MAX_DELAY) : cnt_t'(v);
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Galois LFSR that advances once per enabled cycle; feeds per-beat random extra delay.
module stall_lfsr
  import axi_stall_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SEED;
    end else if (en_i) begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_POLY : 16'h0);
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/axi_chan_stall.sv
// In-order AXI channel delay FIFO: each beat waits FIXED_DELAY cycles (+0..7 random with AXI_CHAN_STALL_RANDOM_EN).
// Upstream ready is NOT full from registered pointers only; a full buffer refuses the push even while popping.
module axi_chan_stall
  import axi_stall_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIXED_DELAY = 2,
  parameter int unsigned DEPTH       = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slv_valid_i,
  output logic                  slv_ready_o,
  input  logic [DATA_WIDTH-1:0] slv_data_i,
  output logic                  mst_valid_o,
  input  logic                  mst_ready_i,
  output logic [DATA_WIDTH-1:0] mst_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (FIXED_DELAY < 1 || FIXED_DELAY > MAX_DELAY || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || LFSR_SEED == 16'h0) begin : g_bad_param
    $error("axi_chan_stall: illegal FIXED_DELAY, DEPTH or LFSR_SEED");
  end

  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic                  r_rdy_en;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  cnt_t                  r_cnt  [DEPTH];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_widx;
  logic [AW-1:0]         w_ridx;
  cnt_t                  w_load;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);

  // r_rdy_en holds ready low while in reset so it rises only after release
  assign slv_ready_o = r_rdy_en & ~w_full;
  assign mst_valid_o = ~w_empty && (r_cnt[w_ridx] == cnt_t'(0));
  assign mst_data_o  = w_empty ? '0 : r_data[w_ridx];

  assign w_push = slv_valid_i & slv_ready_o;
  assign w_pop  = mst_valid_o & mst_ready_i;

`ifdef AXI_CHAN_STALL_RANDOM_EN
  logic [15:0] w_lfsr;

  stall_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_push),
    .state_o(w_lfsr)
  );

  assign w_load = clamp_cnt(FIXED_DELAY - 1 + 32'(w_lfsr[2:0]));
`else
  assign w_load = clamp_cnt(FIXED_DELAY - 1);
`endif

  // Idle slots may count down too: they are reloaded on push, so only occupied ones matter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rdy_en <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_rdy_en <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_cnt[i] != cnt_t'(0)) begin
          r_cnt[i] <= r_cnt[i] - cnt_t'(1);
        end
      end
      if (w_push) begin
        r_data[w_widx] <= slv_data_i;
        r_cnt[w_widx]  <= w_load;
        r_wptr         <= r_wptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW + 1)'(1);
      end
    end
  end

endmodule

// File: doc/axi_chan_stall.md
AXI_CHAN_STALL -- requirements
Module: axi_chan_stall

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning width of the payload carried by one channel beat.
REQ-002 SHALL have parameter FIXED_DELAY, default 2, meaning the minimum accept-to-present latency in cycles; the legal range is 1..15.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of buffered beats; it is a power of two, at least 2.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero initial LFSR state.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port slv_valid_i, input, 1 bit: upstream beat valid.
REQ-008 SHALL have port slv_ready_o, output, 1 bit: upstream beat accepted.
REQ-009 SHALL have port slv_data_i, input, DATA_WIDTH bits: upstream payload.
REQ-010 SHALL have port mst_valid_o, output, 1 bit: downstream beat valid.
REQ-011 SHALL have port mst_ready_i, input, 1 bit: downstream ready.
REQ-012 SHALL have port mst_data_o, output, DATA_WIDTH bits: downstream payload.

Function
REQ-013 SHALL accept a beat in any cycle where slv_valid_i and slv_ready_o are both 1, and pop one on mst_valid_o and mst_ready_i both 1.
REQ-014 SHALL store each accepted beat in an in-order FIFO entry holding the payload and a 4-bit countdown loaded with FIXED_DELAY-1+extra, where extra is 0 unless REQ-024 applies.
REQ-015 SHALL decrement every occupied entry's countdown by 1 each cycle, saturating at 0.
REQ-016 SHALL drive mst_valid_o = FIFO non-empty AND head countdown == 0; a beat accepted in cycle t with extra = 0 is first presented in cycle t+FIXED_DELAY.
REQ-017 SHALL never drop mst_valid_o or change mst_data_o once asserted until the handshake completes (AXI stability rule).
REQ-018 SHALL drive slv_ready_o = NOT full from registered state only; there is no combinational path from mst_ready_i or slv_valid_i to slv_ready_o.
REQ-019 SHALL, when full and popping in the same cycle, refuse the push; at any occupancy below full, it SHALL complete a simultaneous push and pop with occupancy unchanged.
REQ-020 SHALL wrap read and write pointers modulo DEPTH, with an extra pointer bit to distinguish full from empty.
REQ-021 SHALL preserve beat order; a later beat with a shorter countdown waits behind the head (head-of-line blocking).
REQ-022 SHALL drive mst_data_o from registered FIFO storage, X-free after reset, with value 0 when empty.

Reset
REQ-023 SHALL, on rst_ni low at any time including mid-transfer, immediately force empty pointers, slv_ready_o=1 (rising once rst_ni high), mst_valid_o=0, mst_data_o=0, all countdowns 0, LFSR=LFSR_SEED; buffered beats are discarded.

Configuration
REQ-024 SHALL, with macro AXI_CHAN_STALL_RANDOM_EN defined, set extra = LFSR[2:0] (0..7) per accepted beat, advance the 16-bit Galois LFSR (taps 16,14,13,11) once per accepted beat, and clamp the countdown at 15.
REQ-025 SHALL, without AXI_CHAN_STALL_RANDOM_EN, contain no LFSR logic and fix extra = 0, giving deterministic latency FIXED_DELAY.

Structure
REQ-026 SHALL take the LFSR polynomial constant, the 4-bit countdown typedef, and the maximum-delay constant 15 from shared package axi_stall_pkg.
REQ-027 SHALL place the LFSR in sub-module stall_lfsr (ports clk_i, rst_ni, en_i, state_o), instantiated only under AXI_CHAN_STALL_RANDOM_EN.
REQ-028 SHALL be instantiable per AXI channel (AW, W, B, AR, R) in a delayed-bus wrapper that feeds axi2mem.

Verification
REQ-029 SHALL test, with macro off and FIXED_DELAY=2: single beat 0xDEAD accepted in cycle 10 -> mst_valid_o=1, mst_data_o=0xDEAD in cycle 12.
REQ-030 SHALL test, with DEPTH=4 and mst_ready_i=0: 4 beats accepted -> slv_ready_o=0 from the next cycle; a fifth beat is held; one pop -> slv_ready_o=1 the following cycle.
REQ-031 SHALL test back-to-back beats 1..8 with mst_ready_i=1 -> output 1..8 in order, one per cycle after the initial latency, with occupancy stable.
REQ-032 SHALL test mst_ready_i toggled randomly -> mst_valid_o and mst_data_o never change while mst_valid_o=1 and mst_ready_i=0.
REQ-033 SHALL test rst_ni pulsed low with 3 beats buffered -> mst_valid_o=0 immediately, no stale beat emitted after release.
REQ-034 SHALL test, with the macro on and seed 0xACE1: 100 beats -> each latency in 2..9, the latency sequence matches the reference LFSR model, and the data order is intact.
